// File: rtl/fc_pkg.sv
// fc_pkg: shared types, widths and address helpers for the fully-connected layer
package fc_pkg;
    localparam int DATA_W = 20;
    localparam int FRAC_W = 16;
    localparam int ACC_W  = 52;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BIAS  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4
    } state_t;
    function automatic int bias_base(input int n_out, input int n_in, input int o);
        return n_out * n_in + o;
    endfunction
endpackage

// File: rtl/fc_mac.sv
// fc_mac: registered multiplier and accumulator with round/saturate output; ReLU when FC_RELU_EN is defined
module fc_mac
    import fc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load_bias,
    input  logic              mul_en,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);
    localparam int SW = ACC_W - FRAC_W;
    localparam logic signed [ACC_W-1:0] HALF = {{SW{1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [SW-1:0] SAT_HI = SW'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [SW-1:0] shr;
    logic [DATA_W-1:0] sat;
    // product pipeline stage and accumulator; bias load takes priority over accumulate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod <= '0;
            acc  <= '0;
        end else if (clr) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (mul_en) prod <= $signed(a) * $signed(b);
            if (load_bias) acc <= {{(ACC_W-DATA_W){b[DATA_W-1]}}, b} <<< FRAC_W;
            else if (acc_en) acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end
    assign shr = SW'((acc + HALF) >>> FRAC_W);
    assign sat = (shr > SAT_HI) ? SAT_HI[DATA_W-1:0] : (shr < SAT_LO) ? SAT_LO[DATA_W-1:0] : shr[DATA_W-1:0];
`ifdef FC_RELU_EN
    assign result = sat[DATA_W-1] ? '0 : sat;
`else
    assign result = sat;
`endif
endmodule

// File: rtl/fc_layer.sv
// fc_layer: dense layer sequencer over the flatten vector; build with FC_RELU_EN for ReLU outputs
module fc_layer
    import fc_pkg::*;
#(
    parameter int N_IN    = 2048,
    parameter int N_OUT   = 10,
    parameter int WADDR_W = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ready,
    output logic                    busy,
    output logic                    crd,
    output logic [$clog2(N_IN)-1:0] caddr_rd,
    input  logic [DATA_W-1:0]       cdata_rd,
    output logic                    wrd,
    output logic [WADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]       wdata,
    output logic                    owr,
    output logic [3:0]              oaddr,
    output logic [DATA_W-1:0]       odata
);
    localparam int IW = $clog2(N_IN);
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [3:0] O_LAST = 4'(N_OUT - 1);
    state_t state;
    logic [3:0] o;
    logic [IW-1:0] i;
    logic [DATA_W-1:0] result;
    logic in_bias, in_mac;
    // sequencer: one bias fetch, N_IN MAC reads, a drain for the last product, then a write per neuron
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            o     <= '0;
            i     <= '0;
        end else begin
            case (state)
                IDLE:  if (ready) begin state <= BIAS; o <= '0; end
                BIAS:  begin state <= MAC; i <= '0; end
                MAC:   begin i <= i + 1'b1; if (i == I_LAST) state <= DRAIN; end
                DRAIN: state <= WRITE;
                WRITE: begin state <= (o == O_LAST) ? IDLE : BIAS; o <= (o == O_LAST) ? '0 : o + 1'b1; end
                default: state <= IDLE;
            endcase
        end
    end
    assign in_bias  = state == BIAS;
    assign in_mac   = state == MAC;
    assign busy     = state != IDLE;
    assign crd      = in_mac;
    assign wrd      = in_bias || in_mac;
    assign caddr_rd = in_mac ? i : '0;
    assign waddr    = in_bias ? WADDR_W'(bias_base(N_OUT, N_IN, int'(o))) : in_mac ? WADDR_W'(int'(o) * N_IN + int'(i)) : '0;
    assign owr      = state == WRITE;
    assign oaddr    = owr ? o : '0;
    assign odata    = owr ? result : '0;
    fc_mac u_mac (
        .clk       (clk),
        .reset     (reset),
        .clr       (state == IDLE),
        .load_bias (in_bias),
        .mul_en    (in_mac),
        .acc_en    ((in_mac && i != '0) || state == DRAIN),
        .a         (cdata_rd),
        .b         (wdata),
        .result    (result)
    );
endmodule

// File: tb/tb_fc_layer.sv
// tb_fc_layer: directed checks of the dense layer against hand-computed neuron results
module tb_fc_layer;
    localparam int N_IN = 2048;
    localparam int N_OUT = 10;
    localparam int WADDR_W = 15;
    logic clk = 0;
    logic reset, ready;
    logic busy, crd, wrd, owr;
    logic [10:0] caddr_rd;
    logic [19:0] cdata_rd, wdata, odata;
    logic [WADDR_W-1:0] waddr;
    logic [3:0] oaddr;
    logic [19:0] fmem [N_IN];
    logic [19:0] wmem [2**WADDR_W];
    int tests = 0, fails = 0;
    int cyc = 0, busy_cnt = 0, last_owr_cyc = 0, pulse_err = 0;
    logic prev_owr = 0;
    logic [3:0] wa_q [$];
    logic [19:0] wd_q [$];
    logic [19:0] w1 [N_OUT] = '{20'h10000, 20'hF0000, 20'h00000, 20'h10000, 20'h20000, 20'h00001, 20'hFFFFF, 20'h18000, 20'hE0000, 20'h10000};
    logic [19:0] b1 [N_OUT] = '{20'h10000, 20'h00000, 20'h00000, 20'hF0000, 20'h00000, 20'h00000, 20'h00000, 20'h08000, 20'h00000, 20'h7FFFF};
    logic [19:0] g1 [N_OUT] = '{20'h50000, 20'hC0000, 20'h00000, 20'h30000, 20'h7FFFF, 20'h00004, 20'hFFFFC, 20'h68000, 20'h80000, 20'h7FFFF};
    logic [19:0] a2 [N_OUT] = '{20'h08000, 20'h07FFF, 20'hF8000, 20'hF7FFF, 20'h00000, 20'h00000, 20'h18000, 20'hE8000, 20'h00000, 20'h00000};
    logic [19:0] c2 [N_OUT] = '{20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h10000, 20'hF0000, 20'h00000, 20'h00000, 20'h00010, 20'h00000};
    logic [19:0] g2 [N_OUT] = '{20'h00001, 20'h00000, 20'h00000, 20'hFFFFF, 20'h7FFFF, 20'h80000, 20'h00002, 20'hFFFFF, 20'h07FF0, 20'h12345};

    always #5 clk = ~clk;

    fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .WADDR_W(WADDR_W)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .wrd(wrd), .waddr(waddr), .wdata(wdata),
        .owr(owr), .oaddr(oaddr), .odata(odata)
    );

    // memories answer half a cycle after the address edge
    always @(negedge clk) begin
        cdata_rd <= crd ? fmem[caddr_rd] : 20'h0;
        wdata    <= wrd ? wmem[waddr] : 20'h0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // output-side monitor
    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (owr) begin
            wa_q.push_back(oaddr);
            wd_q.push_back(odata);
            last_owr_cyc <= cyc;
            if (prev_owr) pulse_err <= pulse_err + 1;
        end
        prev_owr <= owr;
    end

    function automatic logic [19:0] expect_of(input logic [19:0] v);
`ifdef FC_RELU_EN
        return v[19] ? 20'h0 : v;
`else
        return v;
`endif
    endfunction

    task automatic load_run1();
        for (int i = 0; i < N_IN; i++) fmem[i] = 20'h00080;
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) wmem[o*N_IN+i] = w1[o];
            wmem[N_OUT*N_IN+o] = b1[o];
        end
    endtask

    task automatic load_run2();
        fmem[0] = 20'h00001;
        for (int i = 1; i < N_IN; i++) fmem[i] = 20'h10000;
        for (int o = 0; o < N_OUT; o++) begin
            wmem[o*N_IN] = a2[o];
            for (int i = 1; i < N_IN; i++) wmem[o*N_IN+i] = c2[o];
            wmem[N_OUT*N_IN+o] = (o == 9) ? 20'h12345 : 20'h0;
        end
    endtask

    task automatic wait_idle(input int limit, output int fall_cyc, output bit timed_out);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < limit);
        #1;
        timed_out = busy;
        fall_cyc = cyc;
    endtask

    task automatic test_reset();
        reset = 1;
        ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy, crd, wrd, owr} !== 4'b0) begin fails++; $display("FAIL reset_ctrl got %b want 0000", {busy, crd, wrd, owr}); end
        tests++;
        if ({caddr_rd, waddr, oaddr, odata} !== '0) begin fails++; $display("FAIL reset_addr got caddr=%h waddr=%h oaddr=%h odata=%h want 0", caddr_rd, waddr, oaddr, odata); end
        reset = 0;
        repeat (5) @(negedge clk);
        tests++;
        if ({busy, crd, wrd, owr} !== 4'b0) begin fails++; $display("FAIL idle_no_ready got %b want 0000", {busy, crd, wrd, owr}); end
    endtask

    task automatic test_handshake();
        int base_b, base_q, fall_cyc;
        bit to;
        load_run1();
        @(negedge clk);
        ready = 1;
        base_b = busy_cnt;
        base_q = wa_q.size();
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_rise got %b want 1", busy); end
        tests++;
        if ({crd, wrd, waddr} !== {2'b01, 15'd20480}) begin fails++; $display("FAIL bias_fetch got crd=%b wrd=%b waddr=%0d want 0 1 20480", crd, wrd, waddr); end
        @(posedge clk); #1;
        tests++;
        if ({crd, wrd, caddr_rd, waddr} !== {2'b11, 11'd0, 15'd0}) begin fails++; $display("FAIL mac0_addr got crd=%b wrd=%b caddr=%0d waddr=%0d want 1 1 0 0", crd, wrd, caddr_rd, waddr); end
        @(posedge clk); #1;
        tests++;
        if ({caddr_rd, waddr} !== {11'd1, 15'd1}) begin fails++; $display("FAIL mac1_addr got caddr=%0d waddr=%0d want 1 1", caddr_rd, waddr); end
        wait_idle(25000, fall_cyc, to);
        ready = 0;
        tests++;
        if (to) begin fails++; $display("FAIL hs_timeout busy still %b want 0", busy); end
        tests++;
        if (busy_cnt - base_b !== 20510) begin fails++; $display("FAIL busy_len got %0d want 20510", busy_cnt - base_b); end
        tests++;
        if (wa_q.size() - base_q !== 10) begin fails++; $display("FAIL owr_count got %0d want 10", wa_q.size() - base_q); end
        tests++;
        if (pulse_err !== 0) begin fails++; $display("FAIL owr_pulse got %0d back-to-back strobes want 0", pulse_err); end
        tests++;
        if (fall_cyc !== last_owr_cyc + 1) begin fails++; $display("FAIL busy_fall got cycle %0d want %0d", fall_cyc, last_owr_cyc + 1); end
        for (int k = 0; k < 10 && base_q + k < wa_q.size(); k++) begin
            tests++;
            if (wa_q[base_q+k] !== 4'(k) || wd_q[base_q+k] !== expect_of(g1[k]))
                begin fails++; $display("FAIL run1_n%0d got addr=%0d data=%h want addr=%0d data=%h", k, wa_q[base_q+k], wd_q[base_q+k], k, expect_of(g1[k])); end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL no_restart got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_mac();
        int base_q, n;
        @(negedge clk);
        ready = 1;
        @(negedge clk);
        ready = 0;
        base_q = wa_q.size();
        n = 0;
        while (wa_q.size() - base_q < 3 && n < 10000) begin @(negedge clk); n++; end
        tests++;
        if (wa_q.size() - base_q !== 3) begin fails++; $display("FAIL mid_wait got %0d writes want 3", wa_q.size() - base_q); end
        repeat (200) @(negedge clk);
        reset = 1;
        #1;
        tests++;
        if ({busy, crd, wrd, owr, caddr_rd, waddr} !== '0) begin fails++; $display("FAIL mid_reset got busy=%b crd=%b wrd=%b owr=%b caddr=%0d waddr=%0d want 0", busy, crd, wrd, owr, caddr_rd, waddr); end
        repeat (2) @(negedge clk);
        reset = 0;
        base_q = wa_q.size();
        repeat (3000) @(negedge clk);
        tests++;
        if (wa_q.size() - base_q !== 0 || busy !== 1'b0) begin fails++; $display("FAIL post_reset got writes=%0d busy=%b want 0 0", wa_q.size() - base_q, busy); end
    endtask

    task automatic test_fresh_start();
        int base_b, base_q, fall_cyc;
        bit to;
        @(negedge clk);
        ready = 1;
        base_b = busy_cnt;
        base_q = wa_q.size();
        @(negedge clk);
        ready = 0;
        wait_idle(25000, fall_cyc, to);
        tests++;
        if (to || busy_cnt - base_b !== 20510 || wa_q.size() - base_q !== 10)
            begin fails++; $display("FAIL fresh_run got timeout=%b busy_len=%0d writes=%0d want 0 20510 10", to, busy_cnt - base_b, wa_q.size() - base_q); end
        for (int k = 0; k < 10 && base_q + k < wa_q.size(); k++) begin
            tests++;
            if (wa_q[base_q+k] !== 4'(k) || wd_q[base_q+k] !== expect_of(g1[k]))
                begin fails++; $display("FAIL fresh_n%0d got addr=%0d data=%h want addr=%0d data=%h", k, wa_q[base_q+k], wd_q[base_q+k], k, expect_of(g1[k])); end
        end
    endtask

    task automatic test_round_saturate();
        int base_q, fall_cyc;
        bit to;
        load_run2();
        @(negedge clk);
        ready = 1;
        base_q = wa_q.size();
        @(negedge clk);
        ready = 0;
        wait_idle(25000, fall_cyc, to);
        tests++;
        if (to || wa_q.size() - base_q !== 10) begin fails++; $display("FAIL run2 got timeout=%b writes=%0d want 0 10", to, wa_q.size() - base_q); end
        for (int k = 0; k < 10 && base_q + k < wa_q.size(); k++) begin
            tests++;
            if (wa_q[base_q+k] !== 4'(k) || wd_q[base_q+k] !== expect_of(g2[k]))
                begin fails++; $display("FAIL run2_n%0d got addr=%0d data=%h want addr=%0d data=%h", k, wa_q[base_q+k], wd_q[base_q+k], k, expect_of(g2[k])); end
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_reset_mid_mac();
        test_fresh_start();
        test_round_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fc_layer.md
# fc_layer

Fully-connected (dense) layer stage downstream of the CONV engine. Once the flatten result (layer 2, 2048 × 20-bit signed Q4.16 words) is complete, it computes N_OUT dot products against a weight memory, adds per-neuron biases, rounds and saturates the results, and writes them to an output memory. It uses the same ready/busy start handshake and the same half-cycle read-memory timing as CONV.

## Interface
- N_IN, 2048: flatten vector length. Must be a power of two.
- N_OUT, 10: number of output neurons.
- WADDR_W, 15: weight address width. Must satisfy N_OUT*N_IN + N_OUT ≤ 2^WADDR_W.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready  in  1  start request; sampled only in IDLE.
- busy  out  1  high from accepted start until after the last write.
- crd  out  1  flatten-memory read enable.
- caddr_rd  out  11  flatten address, 0..N_IN-1.
- cdata_rd  in  20  flatten data, signed Q4.16.
- wrd  out  1  weight-memory read enable.
- waddr  out  WADDR_W  weight address. Weight w[o][i] is at o*N_IN+i; bias b[o] is at N_OUT*N_IN+o.
- wdata  in  20  weight or bias, signed Q4.16.
- owr  out  1  output write strobe.
- oaddr  out  4  output neuron index.
- odata  out  20  result, signed Q4.16.

## Operation
- States: IDLE, BIAS, MAC, DRAIN, WRITE.
- IDLE → BIAS when ready=1; busy rises on that edge. ready is ignored while busy.
- BIAS (1 cycle): wrd=1 and waddr=bias address of neuron o. At the end of the cycle, acc ← sign_ext(wdata) << 16.
- MAC (N_IN cycles, i = 0..N_IN-1): crd=wrd=1, caddr_rd=i, waddr=o*N_IN+i. At the end of each cycle, prod ← cdata_rd × wdata (40-bit signed). The acc += prod of the previous cycle is applied in the same edge, except in the first MAC cycle.
- DRAIN (1 cycle): acc += last prod. crd=wrd=0.
- WRITE (1 cycle): owr=1, oaddr=o, odata=sat20((acc + 2^15) >>> 16). Then o++ → BIAS, or, if o = N_OUT-1, → IDLE with busy=0 on that edge.
- Arithmetic: acc is 52-bit signed; no overflow is possible. Rounding is round-half-up. Saturation clamps to the range 0x80000..0x7FFFF.
- crd, wrd and owr are 0 in every state not listed as driving them. Idle address and data outputs are 0.
- Reset mid-operation: return to IDLE immediately; acc, prod and o are cleared; no partial write. A new ready starts again from neuron 0.

## Timing
- Reset values: busy=0, crd=0, wrd=0, owr=0, caddr_rd=0, waddr=0, oaddr=0, odata=0.
- Read timing: address and enable are driven from registers after a rising edge. The memory returns data before the next rising edge, which samples it. This gives zero-wait, one read per cycle.
- Per-neuron latency: 1 + N_IN + 1 + 1 = 2051 cycles.
- busy stays high for exactly N_OUT*(N_IN+3) cycles: 20510 with the defaults.
- owr is a single-cycle pulse. oaddr increments 0..N_OUT-1 in order.

## Configuration
- FC_RELU_EN defined: odata = max(0, saturated result), applied in WRITE with no added latency.
- FC_RELU_EN undefined: the signed saturated result is written unchanged.

## Structure
- Shared package fc_pkg holds:
  - the state enum;
  - DATA_W=20 and FRAC_W=16;
  - ACC_W=52;
  - the bias-base address function.
- One sub-module, fc_mac: the registered multiplier plus accumulator, with load-bias, accumulate and clear controls, the round/saturate output and the optional ReLU. The FSM and address generation stay in fc_layer.

## Test plan
- Reset asserted for 3 cycles → all outputs 0 and state IDLE. busy stays 0 with ready=0.
- All inputs 0x00080, weights for o=0 all 0x10000, b[0]=0x10000 → oaddr 0 written with 0x50000.
- Inputs 0x00080, weights 0xF0000, bias 0 → 0xC0000 without FC_RELU_EN; 0x00000 with FC_RELU_EN.
- Inputs 0x10000, weights 0x10000 → 0x7FFFF. With weights 0xF0000 → 0x80000 (or 0x00000 with ReLU).
- Only input[0]=0x00001, with w[0][0]=0x08000 → 0x00001; with w[0][0]=0x07FFF → 0x00000 (rounding boundary).
- Handshake: ready held high throughout:
  - busy rises 1 edge after start and stays high 20510 cycles;
  - exactly 10 owr pulses, oaddr 0..9 in order;
  - busy falls on the edge after the last WRITE.
- Reset pulsed during MAC of neuron 3 → no owr afterwards. A fresh start reproduces all 10 golden outputs.
